// File: rtl/bcd_to_binary_seq_if.sv
// Handshake and data bundle for the sequential BCD-to-binary converter.
// The master drives the request and the three BCD digits.
// The slave (the converter) returns the registered result and status.
interface bcd_to_binary_seq_if;
  logic       start;
  logic [3:0] H;
  logic [3:0] T;
  logic [3:0] O;
  logic [7:0] bin;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start,
    output H,
    output T,
    output O,
    input  bin,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  start,
    input  H,
    input  T,
    input  O,
    output bin,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential 3-digit BCD to 8-bit binary converter (reverse double-dabble).
// A conversion is captured from IDLE and shifted for 8 cycles.
// The result is then published with a one-cycle done pulse.
// Invalid digits yield err=1 with bin=0.
// Values above 255 yield err=1 with bin saturated to 8'hFF.
module bcd_to_binary_seq (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_to_binary_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [11:0] r_bcd;    // residual BCD digits being shifted out
  logic [7:0]  r_binsr;  // binary result accumulating from the MSB side
  logic [2:0]  r_cnt;    // shift iteration, 0..7
  logic        r_inv;    // an input digit was > 9 when captured
  logic [7:0]  r_bin;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic [11:0] w_digits;
  logic [2:0]  w_digit_bad;
  logic        w_cap_inv;
  logic [19:0] w_shifted;
  logic [11:0] w_bcd_adj;
  logic [7:0]  w_binsr_next;
  logic        w_last;

  // Digits as captured: hundreds in the top nibble, ones in the bottom.
  assign w_digits = {bus.H, bus.T, bus.O};

  // Per-digit validity check on the live inputs.
  // It only matters at the capture edge.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digit_chk
      assign w_digit_bad[gi] = (w_digits[4*gi +: 4] > 4'd9);
    end
  endgenerate

  assign w_cap_inv = |w_digit_bad;

  // One reverse double-dabble step.
  // The whole {bcd, bin} register moves right by one bit.
  // Every BCD nibble that lands at 8 or more then has 3 taken off.
  assign w_shifted = {r_bcd, r_binsr} >> 1;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_nib_adj
      logic [3:0] w_nib;
      assign w_nib = w_shifted[8 + 4*gi +: 4];
      assign w_bcd_adj[4*gi +: 4] = (w_nib >= 4'd8) ? (w_nib - 4'd3) : w_nib;
    end
  endgenerate

  assign w_binsr_next = w_shifted[7:0];
  assign w_last       = (r_cnt == 3'd7);

  // Control FSM and datapath.
  // All outputs are registered here so they change only on clock edges (or reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bcd   <= 12'h000;
      r_binsr <= 8'h00;
      r_cnt   <= 3'd0;
      r_inv   <= 1'b0;
      r_bin   <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_bcd   <= w_digits;
            r_binsr <= 8'h00;
            r_cnt   <= 3'd0;
            r_inv   <= w_cap_inv;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end

        SHIFT: begin
          // start is deliberately not looked at here.
          // A request during a conversion is simply dropped.
          r_bcd   <= w_bcd_adj;
          r_binsr <= w_binsr_next;
          r_cnt   <= r_cnt + 3'd1;
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
            // A bad digit outranks overflow.
            // A non-zero residual after the last step means the value exceeded 255.
            if (r_inv) begin
              r_bin <= 8'h00;
              r_err <= 1'b1;
            end else if (w_bcd_adj != 12'h000) begin
              r_bin <= 8'hFF;
              r_err <= 1'b1;
            end else begin
              r_bin <= w_binsr_next;
              r_err <= 1'b0;
            end
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.bin  = r_bin;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err  = r_err;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq.
// It uses a table of directed vectors, hand-written multi-cycle sequences,
// and random vectors checked against an arithmetic reference model.
module tb_bcd_to_binary_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bcd_to_binary_seq_if bus ();

  bcd_to_binary_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    logic [7:0] bin;
    logic       err;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal value from plain arithmetic.
  // Bad digits give {err=1, bin=0}; values above 255 give {err=1, bin=FF}.
  function automatic logic [8:0] ref_model(input int h, input int t, input int o);
    int v;
    if (h > 9 || t > 9 || o > 9) return {1'b1, 8'h00};
    v = 100 * h + 10 * t + o;
    if (v > 255) return {1'b1, 8'hFF};
    return {1'b0, 8'(v)};
  endfunction

  // One full conversion.
  // It checks busy length, done latency, the done pulse width, and that bin holds mid-conversion.
  task automatic run_conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                          input string tag, input bit release_rst,
                          output logic [7:0] bin_o, output logic err_o);
    int lat;
    int busy_cnt;
    bit seen;
    logic [7:0] prev_bin;
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    bus.H = h; bus.T = t; bus.O = o; bus.start = 1'b1;
    prev_bin = bus.bin;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; busy_cnt = 0; seen = 0;
    while (!seen && lat < 20) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) seen = 1;
      else begin
        if (lat == 4) check({tag, " bin hold"}, bus.bin, prev_bin);
        @(posedge clk); #1;
        lat++;
      end
    end
    check({tag, " done seen"}, seen, 1);
    check({tag, " latency"}, lat, 8);
    check({tag, " busy cycles"}, busy_cnt, 8);
    check({tag, " busy at done"}, bus.busy, 0);
    bin_o = bus.bin;
    err_o = bus.err;
    @(posedge clk); #1;
    check({tag, " done width"}, bus.done, 0);
  endtask

  logic [7:0] rb;
  logic       re;
  logic [8:0] exp_r;
  int         dcnt;
  int         d1;
  int         d2;
  logic [3:0] rh, rt, ro;

  initial begin
    vecs[0] = '{4'h0, 4'h0, 4'h0, 8'h00, 1'b0};
    vecs[1] = '{4'h1, 4'h8, 4'h1, 8'hB5, 1'b0};
    vecs[2] = '{4'h2, 4'h5, 4'h5, 8'hFF, 1'b0};
    vecs[3] = '{4'h2, 4'h5, 4'h6, 8'hFF, 1'b1};
    vecs[4] = '{4'h9, 4'h9, 4'h9, 8'hFF, 1'b1};
    vecs[5] = '{4'h0, 4'hA, 4'h0, 8'h00, 1'b1};
    vecs[6] = '{4'hF, 4'h0, 4'h0, 8'h00, 1'b1};

    bus.start = 1'b0; bus.H = 4'h0; bus.T = 4'h0; bus.O = 4'h0;
    rst_n = 1'b0;
    #1;
    check("reset bin", bus.bin, 8'h00);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset err", bus.err, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      run_conv(vecs[i].h, vecs[i].t, vecs[i].o, $sformatf("vec%0d", i), 1'b0, rb, re);
      check($sformatf("vec%0d bin", i), rb, vecs[i].bin);
      check($sformatf("vec%0d err", i), re, vecs[i].err);
      $display("[TB] vec %0h/%0h/%0h -> bin=%0h err=%0b", vecs[i].h, vecs[i].t, vecs[i].o, rb, re);
    end

    // Input change and start pulse during SHIFT must not disturb the conversion
    @(negedge clk);
    bus.H = 4'h1; bus.T = 4'h2; bus.O = 4'h3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.H = 4'h9; bus.T = 4'h9; bus.O = 4'h9; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dcnt = 0; rb = 8'h00; re = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (bus.done) begin
        dcnt++;
        rb = bus.bin; re = bus.err;
      end
      @(posedge clk); #1;
    end
    check("mid-shift single done", dcnt, 1);
    check("mid-shift bin", rb, 8'h7B);
    check("mid-shift err", re, 0);
    $display("[TB] ignore-start 1/2/3 -> bin=%0h err=%0b dones=%0d", rb, re, dcnt);

    // Reset during the 4th SHIFT cycle aborts the conversion
    @(negedge clk);
    bus.H = 4'h2; bus.T = 4'h0; bus.O = 4'h0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort busy before rst", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", bus.busy, 0);
    check("abort done", bus.done, 0);
    check("abort bin", bus.bin, 8'h00);
    check("abort err", bus.err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.done) dcnt++;
    end
    check("abort no done", dcnt, 0);
    $display("[TB] reset abort 2/0/0 -> later dones=%0d", dcnt);

    // start on the very first edge after reset release is accepted
    @(posedge clk); #1;
    rst_n = 1'b0;
    run_conv(4'h0, 4'h4, 4'h2, "post-reset", 1'b1, rb, re);
    check("post-reset bin", rb, 8'h2A);
    check("post-reset err", re, 0);
    $display("[TB] post-reset 0/4/2 -> bin=%0h err=%0b", rb, re);

    // Randomized vectors against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      rh = 4'($urandom_range(0, (i % 2) ? 15 : 3));
      rt = 4'($urandom_range(0, 11));
      ro = 4'($urandom_range(0, 11));
      exp_r = ref_model(int'(rh), int'(rt), int'(ro));
      run_conv(rh, rt, ro, $sformatf("rnd%0d", i), 1'b0, rb, re);
      check($sformatf("rnd%0d bin", i), rb, exp_r[7:0]);
      check($sformatf("rnd%0d err", i), re, exp_r[8]);
      $display("[TB] rnd %0h/%0h/%0h -> bin=%0h err=%0b", rh, rt, ro, rb, re);
    end

    // start held high: back-to-back conversions, one per 10 cycles
    @(negedge clk);
    bus.H = 4'h0; bus.T = 4'h4; bus.O = 4'h2; bus.start = 1'b1;
    d1 = -1; d2 = -1;
    for (int c = 0; c < 40 && d2 < 0; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (d1 < 0) d1 = c;
        else d2 = c;
        check($sformatf("b2b bin c%0d", c), bus.bin, 8'h2A);
      end
    end
    bus.start = 1'b0;
    check("b2b second done seen", (d2 >= 0), 1);
    check("b2b spacing", d2 - d1, 10);
    $display("[TB] back-to-back dones at %0d and %0d", d1, d2);
    repeat (12) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_seq.md
BCD_TO_BINARY_SEQ -- requirements
Module: bcd_to_binary_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 rising-edge clock; rst_n input 1 asynchronous active-low reset.
REQ-002 The block SHALL have the port start, input, 1 bit: request conversion, sampled on clk rising edge.
REQ-003 The block SHALL have the port H, input, 4 bits: hundreds BCD digit.
REQ-004 The block SHALL have the port T, input, 4 bits: tens BCD digit.
REQ-005 The block SHALL have the port O, input, 4 bits: ones BCD digit.
REQ-006 The block SHALL have the port bin, output, 8 bits: converted binary result, registered.
REQ-007 The block SHALL have the port busy, output, 1 bit: high while a conversion is shifting.
REQ-008 The block SHALL have the port done, output, 1 bit: one-cycle pulse when bin and err are updated.
REQ-009 The block SHALL have the port err, output, 1 bit: last conversion had an invalid digit or a value above 255.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, SHIFT and DONE, all outputs registered.
REQ-011 In IDLE with start=1 at a rising edge E0, the block SHALL capture {H,T,O} into a 12-bit BCD register, clear the 8-bit binary shift register and the iteration counter, and enter SHIFT.
REQ-012 The block SHALL ignore start in SHIFT and DONE, with no capture and no effect on the conversion in flight.
REQ-013 Each SHIFT cycle SHALL shift the 20-bit register {bcd,binsr} right by 1, then subtract 3 from each 4-bit bcd nibble whose value after the shift is >= 8 (reverse double-dabble).
REQ-014 SHIFT SHALL last exactly 8 cycles (edges E1..E8), counted by a 3-bit counter; at E8 the FSM SHALL enter DONE.
REQ-015 busy SHALL be 1 exactly while the state is SHIFT, i.e. the 8 cycles after E0.
REQ-016 At E8 the block SHALL load the bin and err outputs, and done SHALL be 1 for exactly the one cycle the state is DONE; at E9 the FSM SHALL return to IDLE.
REQ-017 Latency SHALL be 8 cycles: done is high in the cycle after E8, 9 cycles after the cycle start was sampled; the maximum start-to-start rate is one conversion per 10 cycles.
REQ-018 Invalid digit: if any captured nibble is > 9, the result SHALL be err=1 and bin=8'h00; this case takes precedence over overflow.
REQ-019 Overflow: if all digits are valid and the residual bcd register is non-zero after 8 shifts (value > 255), the result SHALL be err=1 and bin=8'hFF (saturate).
REQ-020 Otherwise the result SHALL be err=0 and bin = 100*H + 10*T + O.
REQ-021 The invalid-digit check SHALL use the digits captured at E0; input changes after E0 SHALL NOT affect the result.
REQ-022 bin and err SHALL hold their values between done pulses and change only at a DONE-entry edge.
REQ-023 start held high continuously SHALL produce back-to-back conversions: a new capture in each IDLE cycle, one conversion per 10 cycles.

Reset
REQ-024 While rst_n=0, the block SHALL immediately (asynchronously) force the state to IDLE, bin=8'h00, busy=0, done=0, err=0, and clear the internal registers and counter.
REQ-025 Reset asserted mid-SHIFT or in DONE SHALL abort the conversion; no done pulse SHALL follow, and bin/err SHALL read zero.
REQ-026 After rst_n deasserts, the first rising edge SHALL be treated as in IDLE, and start=1 on that edge SHALL be accepted.

Verification
REQ-027 The bench SHALL apply start with H/T/O=0/0/0 and check busy high for 8 cycles, done after 9 cycles, bin=8'h00 and err=0.
REQ-028 The bench SHALL apply H/T/O=1/8/1 and check bin=8'hB5 and err=0; it SHALL apply 2/5/5 and check bin=8'hFF and err=0.
REQ-029 The bench SHALL apply H/T/O=2/5/6 and check bin=8'hFF and err=1; it SHALL apply 9/9/9 and check bin=8'hFF and err=1.
REQ-030 The bench SHALL apply H/T/O=0/A/0 and check bin=8'h00 and err=1; it SHALL apply F/0/0 and check bin=8'h00 and err=1 (invalid digit takes precedence).
REQ-031 The bench SHALL capture 1/2/3, change the inputs to 9/9/9 and pulse start during SHIFT, and check a single done with bin=8'h7B and err=0.
REQ-032 The bench SHALL start 2/0/0, assert rst_n=0 at the 4th SHIFT cycle, and check busy=0, done=0 and bin=8'h00 immediately with no later done; then, after release, it SHALL start 0/4/2 and check bin=8'h2A.
